// File: rtl/fpu_pkg.sv
// Shared FP sequencing definitions: operand type codes, rounding modes,
// fflags bit positions and the convert-sequencer state encoding.
package fpu_pkg;

  localparam logic [1:0] FP_TYPE_FP32   = 2'b00;
  localparam logic [1:0] FP_TYPE_FP64   = 2'b01;
  localparam logic [1:0] FP_TYPE_INT32  = 2'b10;
  localparam logic [1:0] FP_TYPE_UINT32 = 2'b11;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  localparam int FFLAG_NX = 0;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_NV = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } cvt_state_e;

  // Converter flags {invalid,overflow,underflow,inexact} -> fflags {NV,DZ,OF,UF,NX}.
  // The convert unit can never raise divide-by-zero.
  function automatic logic [4:0] map_cvt_flags(input logic [3:0] flags);
    logic [4:0] f;
    f           = 5'b00000;
    f[FFLAG_NV] = flags[3];
    f[FFLAG_DZ] = 1'b0;
    f[FFLAG_OF] = flags[2];
    f[FFLAG_UF] = flags[1];
    f[FFLAG_NX] = flags[0];
    return f;
  endfunction

endpackage

// File: rtl/fpu_rm_resolve.sv
// Combinational rounding-mode resolution (instruction rm vs. frm CSR) and
// legality check for FP32 <-> 32-bit integer conversions.
module fpu_rm_resolve
  import fpu_pkg::*;
(
  input  logic [2:0] rm,
  input  logic [2:0] frm,
  input  logic [1:0] in_type,
  input  logic [1:0] out_type,
  output logic [2:0] rm_resolved,
  output logic       illegal
);

  logic rm_bad_s;
  logic pair_ok_s;

  // Resolve dynamic rounding and flag reserved modes or unsupported type pairs.
  always_comb begin
    rm_resolved = rm;
    rm_bad_s    = 1'b0;
    pair_ok_s   = 1'b0;
    if (rm == RM_DYN) begin
      rm_resolved = frm;
    end else begin
      rm_resolved = rm;
    end
    case (rm_resolved)
      RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM: rm_bad_s = 1'b0;
      default:                                rm_bad_s = 1'b1;
    endcase
    case ({in_type, out_type})
      {FP_TYPE_FP32,   FP_TYPE_INT32},
      {FP_TYPE_FP32,   FP_TYPE_UINT32},
      {FP_TYPE_INT32,  FP_TYPE_FP32},
      {FP_TYPE_UINT32, FP_TYPE_FP32}: pair_ok_s = 1'b1;
      default:                        pair_ok_s = 1'b0;
    endcase
    illegal = rm_bad_s | ~pair_ok_s;
  end

endmodule

// File: rtl/fpu_cvt_sequencer.sv
// Sequencer in front of the FP32 convert unit: accepts FCVT requests,
// resolves rounding, drives the converter until done, returns a response
// and keeps the sticky fflags field.
// Optional build macro FPU_CVT_PERF_EN adds conversion / inexact counters.
module fpu_cvt_sequencer
  import fpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [XLEN-1:0]  req_operand,
  input  logic [1:0]       req_in_type,
  input  logic [1:0]       req_out_type,
  input  logic [2:0]       req_rm,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  input  logic [2:0]       csr_frm,
  input  logic             csr_fflags_we,
  input  logic [4:0]       csr_fflags_wdata,
  output logic [4:0]       fflags,
  output logic             cvt_start,
  output logic [XLEN-1:0]  cvt_operand,
  output logic [1:0]       cvt_in_type,
  output logic [1:0]       cvt_out_type,
  output logic [2:0]       cvt_rm,
  input  logic             cvt_done,
  input  logic [XLEN-1:0]  cvt_result,
  input  logic [3:0]       cvt_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_illegal
`ifdef FPU_CVT_PERF_EN
  ,
  output logic [31:0]      perf_cvt_count,
  output logic [31:0]      perf_inexact_count
`endif
);

  cvt_state_e       state_r;
  cvt_state_e       state_next_s;
  logic             accept_s;
  logic             capture_s;
  logic [2:0]       rm_resolved_s;
  logic             illegal_s;
  logic [4:0]       flag_accum_s;

  logic             req_ready_r;
  logic             cvt_start_r;
  logic             rsp_valid_r;
  logic [XLEN-1:0]  cvt_operand_r;
  logic [1:0]       cvt_in_type_r;
  logic [1:0]       cvt_out_type_r;
  logic [2:0]       cvt_rm_r;
  logic [XLEN-1:0]  rsp_result_r;
  logic [TAG_W-1:0] rsp_tag_r;
  logic             rsp_illegal_r;
  logic [4:0]       fflags_r;

  fpu_rm_resolve u_rm_resolve (
    .rm          (req_rm),
    .frm         (csr_frm),
    .in_type     (req_in_type),
    .out_type    (req_out_type),
    .rm_resolved (rm_resolved_s),
    .illegal     (illegal_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; flush overrides every transition including accept.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          state_next_s = ST_IDLE;
        end else if (req_valid) begin
          accept_s     = 1'b1;
          state_next_s = illegal_s ? ST_RESP : ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          state_next_s = ST_IDLE;
        end else if (cvt_done) begin
          capture_s    = 1'b1;
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_RESP: begin
        if (flush || rsp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Flags contributed by a conversion completing this cycle (none if flushed).
  always_comb begin
    if (capture_s) begin
      flag_accum_s = map_cvt_flags(cvt_flags);
    end else begin
      flag_accum_s = 5'b00000;
    end
  end

  // Registered handshake/control outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r <= 1'b0;
      cvt_start_r <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      req_ready_r <= (state_next_s == ST_IDLE);
      cvt_start_r <= (state_next_s == ST_ISSUE);
      rsp_valid_r <= (state_next_s == ST_RESP);
    end
  end

  // Request latch on accept and result capture on converter done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cvt_operand_r  <= {XLEN{1'b0}};
      cvt_in_type_r  <= 2'b00;
      cvt_out_type_r <= 2'b00;
      cvt_rm_r       <= 3'b000;
      rsp_result_r   <= {XLEN{1'b0}};
      rsp_tag_r      <= {TAG_W{1'b0}};
      rsp_illegal_r  <= 1'b0;
    end else if (accept_s) begin
      cvt_operand_r  <= req_operand;
      cvt_in_type_r  <= req_in_type;
      cvt_out_type_r <= req_out_type;
      cvt_rm_r       <= rm_resolved_s;
      rsp_result_r   <= {XLEN{1'b0}};
      rsp_tag_r      <= req_tag;
      rsp_illegal_r  <= illegal_s;
    end else if (capture_s) begin
      rsp_result_r   <= cvt_result;
    end else begin
      rsp_result_r   <= rsp_result_r;
    end
  end

  // Sticky fflags; a CSR write merges with flags accrued in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_r <= 5'b00000;
    end else if (csr_fflags_we) begin
      fflags_r <= csr_fflags_wdata | flag_accum_s;
    end else begin
      fflags_r <= fflags_r | flag_accum_s;
    end
  end

`ifdef FPU_CVT_PERF_EN
  logic [31:0] perf_cvt_count_r;
  logic [31:0] perf_inexact_count_r;

  // Completed-conversion and inexact-result counters (wrap naturally).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cvt_count_r     <= 32'd0;
      perf_inexact_count_r <= 32'd0;
    end else if (capture_s) begin
      perf_cvt_count_r     <= perf_cvt_count_r + 32'd1;
      perf_inexact_count_r <= perf_inexact_count_r + {31'd0, cvt_flags[0]};
    end else begin
      perf_cvt_count_r     <= perf_cvt_count_r;
      perf_inexact_count_r <= perf_inexact_count_r;
    end
  end

  assign perf_cvt_count     = perf_cvt_count_r;
  assign perf_inexact_count = perf_inexact_count_r;
`endif

  assign req_ready    = req_ready_r;
  assign cvt_start    = cvt_start_r;
  assign cvt_operand  = cvt_operand_r;
  assign cvt_in_type  = cvt_in_type_r;
  assign cvt_out_type = cvt_out_type_r;
  assign cvt_rm       = cvt_rm_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_result   = rsp_result_r;
  assign rsp_tag      = rsp_tag_r;
  assign rsp_illegal  = rsp_illegal_r;
  assign fflags       = fflags_r;

endmodule

// File: tb/tb_fpu_cvt_sequencer.sv
// Self-checking bench for fpu_cvt_sequencer. The bench plays the convert unit
// and writeback stage; a reference model tracks legality, resolved rounding
// and the sticky fflags value.
module tb_fpu_cvt_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_operand = 32'd0;
  logic [1:0]  req_in_type = 2'd0;
  logic [1:0]  req_out_type = 2'd0;
  logic [2:0]  req_rm = 3'd0;
  logic [4:0]  req_tag = 5'd0;
  logic        flush = 1'b0;
  logic [2:0]  csr_frm = 3'd0;
  logic        csr_fflags_we = 1'b0;
  logic [4:0]  csr_fflags_wdata = 5'd0;
  logic [4:0]  fflags;
  logic        cvt_start;
  logic [31:0] cvt_operand;
  logic [1:0]  cvt_in_type;
  logic [1:0]  cvt_out_type;
  logic [2:0]  cvt_rm;
  logic        cvt_done = 1'b0;
  logic [31:0] cvt_result = 32'd0;
  logic [3:0]  cvt_flags = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_tag;
  logic        rsp_illegal;

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] model_fflags = 5'd0;

  fpu_cvt_sequencer #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_operand(req_operand),
    .req_in_type(req_in_type), .req_out_type(req_out_type), .req_rm(req_rm),
    .req_tag(req_tag), .flush(flush), .csr_frm(csr_frm),
    .csr_fflags_we(csr_fflags_we), .csr_fflags_wdata(csr_fflags_wdata),
    .fflags(fflags), .cvt_start(cvt_start), .cvt_operand(cvt_operand),
    .cvt_in_type(cvt_in_type), .cvt_out_type(cvt_out_type), .cvt_rm(cvt_rm),
    .cvt_done(cvt_done), .cvt_result(cvt_result), .cvt_flags(cvt_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Legal iff resolved rm is one of the five defined modes and the pair is
  // FP32 <-> INT32/UINT32 (codes: 0 FP32, 1 FP64, 2 INT32, 3 UINT32).
  function automatic bit ref_legal(input int it, input int ot, input int rm, input int frm);
    int r;
    r = (rm == 7) ? frm : rm;
    if (r > 4) return 1'b0;
    if (it == 0 && (ot == 2 || ot == 3)) return 1'b1;
    if (ot == 0 && (it == 2 || it == 3)) return 1'b1;
    return 1'b0;
  endfunction

  // flush_mode: 0 normal, 1 flush while waiting for done, 2 flush together with done.
  task automatic run_txn(input logic [31:0] op, input logic [1:0] it, input logic [1:0] ot,
                         input logic [2:0] rm, input logic [2:0] frm, input logic [4:0] tag,
                         input int dly, input logic [31:0] res, input logic [3:0] fl,
                         input int hold, input int flush_mode,
                         input bit csr_we, input logic [4:0] csr_wd);
    bit         legal;
    logic [2:0] exp_rm;
    logic [4:0] mapped;
    legal  = ref_legal(int'(it), int'(ot), int'(rm), int'(frm));
    exp_rm = (rm == 3'd7) ? frm : rm;
    mapped = {fl[3], 1'b0, fl[2], fl[1], fl[0]};
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_operand = op; req_in_type = it; req_out_type = ot;
    req_rm = rm; csr_frm = frm; req_tag = tag;
    @(negedge clk);
    req_valid = 1'b0;
    if (!legal) begin
      check_eq("ill_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("ill_flag", 32'(rsp_illegal), 32'd1);
      check_eq("ill_result", rsp_result, 32'd0);
      check_eq("ill_no_start", 32'(cvt_start), 32'd0);
      check_eq("ill_tag", 32'(rsp_tag), 32'(tag));
      check_eq("ill_fflags", 32'(fflags), 32'(model_fflags));
    end else begin
      for (int k = 0; k <= dly; k++) begin
        check_eq("start", 32'(cvt_start), 32'd1);
        check_eq("cvt_rm", 32'(cvt_rm), 32'(exp_rm));
        check_eq("cvt_operand", cvt_operand, op);
        check_eq("cvt_types", 32'({cvt_in_type, cvt_out_type}), 32'({it, ot}));
        check_eq("no_rsp_in_issue", 32'(rsp_valid), 32'd0);
        if (k < dly) @(negedge clk);
      end
      if (flush_mode == 1) begin
        flush = 1'b1;
      end else begin
        cvt_done = 1'b1; cvt_result = res; cvt_flags = fl;
        flush = (flush_mode == 2);
        csr_fflags_we = csr_we; csr_fflags_wdata = csr_wd;
      end
      @(negedge clk);
      cvt_done = 1'b0; flush = 1'b0; csr_fflags_we = 1'b0;
      cvt_result = $urandom; cvt_flags = 4'($urandom);
      if (flush_mode != 0) begin
        check_eq("flush_no_rsp", 32'(rsp_valid), 32'd0);
        check_eq("flush_no_start", 32'(cvt_start), 32'd0);
        check_eq("flush_ready", 32'(req_ready), 32'd1);
        check_eq("flush_fflags", 32'(fflags), 32'(model_fflags));
        return;
      end
      model_fflags = (csr_we ? csr_wd : model_fflags) | mapped;
      check_eq("rsp_valid_lat", 32'(rsp_valid), 32'd1);
      check_eq("rsp_illegal", 32'(rsp_illegal), 32'd0);
      check_eq("rsp_result", rsp_result, res);
      check_eq("rsp_tag", 32'(rsp_tag), 32'(tag));
      check_eq("fflags", 32'(fflags), 32'(model_fflags));
      check_eq("resp_not_ready", 32'(req_ready), 32'd0);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_result", rsp_result, legal ? res : 32'd0);
      check_eq("hold_tag", 32'(rsp_tag), 32'(tag));
      check_eq("hold_cvt_rm", 32'(cvt_rm), 32'(exp_rm));
      check_eq("hold_no_start", 32'(cvt_start), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_drop", 32'(rsp_valid), 32'd0);
    check_eq("ready_after_rsp", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [1:0] it, ot;
    int fm;
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_start", 32'(cvt_start), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_fflags", 32'(fflags), 32'd0);
    check_eq("rst_rsp_result", rsp_result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(req_ready), 32'd1);

    // 1.5 -> 2 with NX
    run_txn(32'h3FC00000, 2'd0, 2'd2, 3'd0, 3'd0, 5'd1, 0, 32'h00000002, 4'b0001, 0, 0, 1'b0, 5'd0);
    // 7 -> 7.0 with dynamic rm from frm=RDN
    run_txn(32'h00000007, 2'd2, 2'd0, 3'd7, 3'd2, 5'd2, 1, 32'h40E00000, 4'b0000, 1, 0, 1'b0, 5'd0);
    // NaN -> 0x7FFFFFFF with NV, then an exact conversion keeps NV sticky
    run_txn(32'h7FC00000, 2'd0, 2'd2, 3'd0, 3'd0, 5'd3, 0, 32'h7FFFFFFF, 4'b1000, 0, 0, 1'b0, 5'd0);
    run_txn(32'h00000004, 2'd3, 2'd0, 3'd1, 3'd0, 5'd4, 2, 32'h40800000, 4'b0000, 0, 0, 1'b0, 5'd0);
    // illegal: reserved rm, FP64 source, dynamic with invalid frm
    run_txn(32'h12345678, 2'd0, 2'd2, 3'd5, 3'd0, 5'd5, 0, 32'd0, 4'd0, 2, 0, 1'b0, 5'd0);
    run_txn(32'h12345678, 2'd1, 2'd2, 3'd0, 3'd0, 5'd6, 0, 32'd0, 4'd0, 0, 0, 1'b0, 5'd0);
    run_txn(32'h12345678, 2'd0, 2'd3, 3'd7, 3'd7, 5'd7, 0, 32'd0, 4'd0, 0, 0, 1'b0, 5'd0);
    // done held off 3 cycles then flushed; flush coinciding with done
    run_txn(32'h3F800000, 2'd0, 2'd2, 3'd0, 3'd0, 5'd8, 3, 32'd1, 4'b1111, 0, 1, 1'b0, 5'd0);
    run_txn(32'h3F800000, 2'd0, 2'd2, 3'd0, 3'd0, 5'd9, 0, 32'd1, 4'b1111, 0, 2, 1'b0, 5'd0);
    // CSR write 0x04 merged with inexact capture -> 0x05, response held 4 cycles
    run_txn(32'h3FC00000, 2'd0, 2'd2, 3'd0, 3'd0, 5'd10, 0, 32'h00000002, 4'b0001, 4, 0, 1'b1, 5'h04);
    check_eq("csr_merge", 32'(fflags), 32'h05);

    for (int i = 0; i < 60; i++) begin
      it = 2'($urandom_range(0, 3));
      ot = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 1) == 0) begin it = 2'd0; ot = 2'($urandom_range(2, 3)); end
        else begin ot = 2'd0; it = 2'($urandom_range(2, 3)); end
      end
      fm = $urandom_range(0, 7);
      fm = (fm == 6) ? 1 : ((fm == 7) ? 2 : 0);
      run_txn($urandom, it, ot, 3'($urandom_range(0, 7)),
              3'(($urandom_range(0, 5) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4)),
              5'($urandom), $urandom_range(0, 3), $urandom, 4'($urandom),
              $urandom_range(0, 2), fm,
              (fm == 0) && ($urandom_range(0, 4) == 0), 5'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
